// File: rtl/mem_slave_responder_if.sv
// Memory bus between the initiator (master) and mem_slave_responder (slave).
// Carries the request fields plus the registered read return, status pulses and counters.
interface mem_slave_responder_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_valid;
    logic                  rd_uninit;
    logic                  ready;
    logic                  access_err;
    logic [CNT_WIDTH-1:0]  wr_cnt;
    logic [CNT_WIDTH-1:0]  rd_cnt;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  rdata, rd_valid, rd_uninit, ready, access_err, wr_cnt, rd_cnt
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output rdata, rd_valid, rd_uninit, ready, access_err, wr_cnt, rd_cnt
    );
endinterface

// File: rtl/mem_slave_responder.sv
// Responder end of the small memory bus: storage, post-reset init sequencer, registered reads,
// written flags, saturating counters. Define MEM_RD_BYPASS_EN for write-first same-address reads.
module mem_slave_responder #(
    parameter int                    ADDR_WIDTH = 2,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_slave_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [ADDR_WIDTH-1:0] init_ptr_reg;
    logic [DEPTH-1:0]      written_reg;
    logic [DEPTH-1:0]      written_set;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  rd_valid_reg;
    logic                  rd_uninit_reg;
    logic                  ready_reg;
    logic                  access_err_reg;
    logic [CNT_WIDTH-1:0]  wr_cnt_reg;
    logic [CNT_WIDTH-1:0]  rd_cnt_reg;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_data_next;

    assign wr_fire = (state_reg == ST_READY) && bus.wr_en;
    assign rd_fire = (state_reg == ST_READY) && bus.rd_en;

    // The init sequencer and the bus share the single write port; they never overlap in time.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_ptr_reg;
        mem_wdata = INIT_VAL;
        if (!reset) begin
            if (state_reg == ST_INIT) begin
                mem_we = 1'b1;
            end else if (wr_fire) begin
                mem_we    = 1'b1;
                mem_waddr = bus.addr;
                mem_wdata = bus.wdata;
            end
        end
    end

`ifdef MEM_RD_BYPASS_EN
    assign rd_data_next = bus.wr_en ? bus.wdata : mem_reg[bus.addr];
`else
    assign rd_data_next = mem_reg[bus.addr];
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_reg[mem_waddr] <= mem_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_written
            assign written_set[gi] = wr_fire && (bus.addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_INIT;
            init_ptr_reg   <= '0;
            written_reg    <= '0;
            rdata_reg      <= '0;
            rd_valid_reg   <= 1'b0;
            rd_uninit_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            access_err_reg <= 1'b0;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
        end else begin
            rd_valid_reg   <= rd_fire;
            // Flag sampled before this edge's write, so a same-address collision reports the old state.
            rd_uninit_reg  <= rd_fire && !written_reg[bus.addr];
            access_err_reg <= (state_reg == ST_INIT) && (bus.wr_en || bus.rd_en);
            written_reg    <= written_reg | written_set;
            if (rd_fire) begin
                rdata_reg <= rd_data_next;
            end
            if (wr_fire && (wr_cnt_reg != '1)) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
            if (rd_fire && (rd_cnt_reg != '1)) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
            unique case (state_reg)
                ST_INIT: begin
                    init_ptr_reg <= init_ptr_reg + 1'b1;
                    if (init_ptr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
                        ready_reg <= 1'b1;
                        state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                end
            endcase
        end
    end

    assign bus.rdata      = rdata_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.rd_uninit  = rd_uninit_reg;
    assign bus.ready      = ready_reg;
    assign bus.access_err = access_err_reg;
    assign bus.wr_cnt     = wr_cnt_reg;
    assign bus.rd_cnt     = rd_cnt_reg;
endmodule

// File: tb/tb_mem_slave_responder.sv
// Directed bench for mem_slave_responder: a default instance plus a CNT_WIDTH=2 instance
// driven with identical stimulus to observe counter saturation.
module tb_mem_slave_responder;
    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;

`ifdef MEM_RD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_slave_responder_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
    mem_slave_responder_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(2))  bus_s ();

    mem_slave_responder #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(16), .INIT_VAL(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_slave_responder #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(2), .INIT_VAL(8'h00)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive both instances, advance one edge, then sample 1 time unit after it.
    task automatic cycle(input logic we, input logic re, input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = we;  bus.rd_en   = re;  bus.addr   = a;  bus.wdata   = d;
        bus_s.wr_en = we;  bus_s.rd_en = re;  bus_s.addr = a;  bus_s.wdata = d;
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b wr=%0b rd=%0b addr=%0d wdata=%h -> rdata=%h vld=%0b uninit=%0b rdy=%0b err=%0b wc=%0d rc=%0d",
                 $time, reset, we, re, a, d, bus.rdata, bus.rd_valid, bus.rd_uninit,
                 bus.ready, bus.access_err, bus.wr_cnt, bus.rd_cnt);
    endtask

    task automatic expect_read(input string tag, input logic [7:0] data, input logic uninit);
        check({tag, "_valid"},  32'(bus.rd_valid),  32'd1);
        check({tag, "_data"},   32'(bus.rdata),     32'(data));
        check({tag, "_uninit"}, 32'(bus.rd_uninit), 32'(uninit));
    endtask

    initial begin
        reset = 1'b1;
        cycle(0, 0, 2'd0, 8'h00);
        cycle(0, 0, 2'd0, 8'h00);
        check("rst_ready",  32'(bus.ready),      32'd0);
        check("rst_rdata",  32'(bus.rdata),      32'h00);
        check("rst_valid",  32'(bus.rd_valid),   32'd0);
        check("rst_err",    32'(bus.access_err), 32'd0);
        check("rst_wr_cnt", 32'(bus.wr_cnt),     32'd0);
        check("rst_rd_cnt", 32'(bus.rd_cnt),     32'd0);

        // Init sequence with a write attempt on the second edge
        reset = 1'b0;
        cycle(0, 0, 2'd0, 8'h00);
        check("init1_ready", 32'(bus.ready), 32'd0);
        cycle(1, 0, 2'd2, 8'h55);
        check("init2_err",   32'(bus.access_err), 32'd1);
        check("init2_ready", 32'(bus.ready),      32'd0);
        cycle(0, 0, 2'd0, 8'h00);
        check("init3_err",   32'(bus.access_err), 32'd0);
        check("init3_ready", 32'(bus.ready),      32'd0);
        cycle(0, 0, 2'd0, 8'h00);
        check("init4_ready", 32'(bus.ready),  32'd1);
        check("init_wr_cnt", 32'(bus.wr_cnt), 32'd0);

        cycle(0, 1, 2'd2, 8'h00);
        expect_read("rd2_init", 8'h00, 1'b1);
        check("ready_err", 32'(bus.access_err), 32'd0);
        cycle(0, 0, 2'd0, 8'h00);
        check("idle_valid",  32'(bus.rd_valid),  32'd0);
        check("idle_uninit", 32'(bus.rd_uninit), 32'd0);
        check("idle_hold",   32'(bus.rdata),     32'h00);

        // Write then read back
        cycle(1, 0, 2'd1, 8'hA5);
        check("wr1_cnt", 32'(bus.wr_cnt), 32'd1);
        check("wr1_novalid", 32'(bus.rd_valid), 32'd0);
        cycle(0, 1, 2'd1, 8'h00);
        expect_read("rd1", 8'hA5, 1'b0);
        check("rd1_cnt", 32'(bus.rd_cnt), 32'd2);
        cycle(0, 0, 2'd0, 8'h00);
        check("rd1_pulse", 32'(bus.rd_valid), 32'd0);
        check("rd1_hold",  32'(bus.rdata),    32'hA5);

        // Same-address collision, then back-to-back reads
        cycle(1, 0, 2'd3, 8'h11);
        cycle(1, 1, 2'd3, 8'h22);
        expect_read("coll3", BYPASS ? 8'h22 : 8'h11, 1'b0);
        cycle(0, 1, 2'd3, 8'h00);
        expect_read("after_coll3", 8'h22, 1'b0);

        cycle(1, 0, 2'd0, 8'h0F);
        cycle(1, 0, 2'd1, 8'hF0);
        cycle(0, 1, 2'd0, 8'h00);
        expect_read("b2b_rd0", 8'h0F, 1'b0);
        cycle(0, 1, 2'd1, 8'h00);
        expect_read("b2b_rd1", 8'hF0, 1'b0);

        // Collision on a never-written entry reports the pre-write flag
        cycle(1, 1, 2'd2, 8'h77);
        expect_read("coll2", BYPASS ? 8'h77 : 8'h00, 1'b1);
        cycle(0, 0, 2'd0, 8'h00);
        check("wr_cnt6",     32'(bus.wr_cnt),   32'd6);
        check("rd_cnt7",     32'(bus.rd_cnt),   32'd7);
        check("sat_wr_cnt",  32'(bus_s.wr_cnt), 32'd3);
        check("sat_rd_cnt",  32'(bus_s.rd_cnt), 32'd3);

        // Reset pulse during a read request
        reset = 1'b1;
        cycle(0, 1, 2'd0, 8'h00);
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.ready),    32'd0);
        check("mid_rst_wcnt",  32'(bus.wr_cnt),   32'd0);
        check("mid_rst_rcnt",  32'(bus.rd_cnt),   32'd0);
        check("mid_rst_rdata", 32'(bus.rdata),    32'h00);
        check("sat_rst_wcnt",  32'(bus_s.wr_cnt), 32'd0);
        reset = 1'b0;
        cycle(0, 0, 2'd0, 8'h00);
        check("reinit1_ready", 32'(bus.ready), 32'd0);
        cycle(1, 1, 2'd1, 8'h99);
        check("reinit2_err",   32'(bus.access_err), 32'd1);
        check("reinit2_valid", 32'(bus.rd_valid),   32'd0);
        check("reinit2_ready", 32'(bus.ready),      32'd0);
        cycle(0, 0, 2'd0, 8'h00);
        check("reinit3_err",   32'(bus.access_err), 32'd0);
        check("reinit3_ready", 32'(bus.ready),      32'd0);
        cycle(0, 0, 2'd0, 8'h00);
        check("reinit4_ready", 32'(bus.ready),  32'd1);
        check("reinit_wcnt",   32'(bus.wr_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 2'(i), 8'h00);
            expect_read($sformatf("clr_rd%0d", i), 8'h00, 1'b1);
        end
        cycle(0, 0, 2'd0, 8'h00);
        check("clr_rd_cnt", 32'(bus.rd_cnt),   32'd4);
        check("clr_valid",  32'(bus.rd_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
